// File: rtl/row_dwt97_lift_pair.sv
// One predict+update lifting pair of the row 9/7 DWT, symmetric row ends.
// Lanes share control; output pairs are row-aligned (no priming outputs).
module row_dwt97_lift_pair #(
    parameter int DataWidth   = 16,
    parameter int Point       = 10,
    parameter int CoefWidth   = 18,
    parameter int PredictCoef = -1624,
    parameter int UpdateCoef  = -54,
    parameter int Lanes       = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    output logic                         s_ready_o,
    input  logic                         s_valid_i,
    input  logic                         s_sof_i,
    input  logic                         s_eol_i,
    input  logic [Lanes*2*DataWidth-1:0] s_data_i,
    input  logic                         m_ready_i,
    output logic                         m_valid_o,
    output logic                         m_sof_o,
    output logic                         m_eol_o,
    output logic [Lanes*2*DataWidth-1:0] m_data_o
);

    localparam int DW = DataWidth;
    localparam int SW = DW + 1;
    localparam int PW = SW + CoefWidth;
    localparam int LW = 2 * DW;

    localparam logic signed [CoefWidth-1:0] PCoef = CoefWidth'(PredictCoef);
    localparam logic signed [CoefWidth-1:0] UCoef = CoefWidth'(UpdateCoef);
    localparam logic signed [PW-1:0] Half = PW'(1) <<< (Point - 1);
    localparam logic signed [PW:0] MaxV = (PW + 1)'(2 ** (DW - 1) - 1);
    localparam logic signed [PW:0] MinV = -MaxV - 1;

    typedef enum logic [1:0] {
        EMPTY,
        HELD,
        FLUSH
    } state_e;

    function automatic logic signed [DW-1:0] lift(
        input logic signed [DW-1:0]        base,
        input logic signed [SW-1:0]        sum,
        input logic signed [CoefWidth-1:0] coef
    );
        logic signed [PW-1:0] prod;
        logic signed [PW:0]   acc;
        prod = PW'(sum) * PW'(coef);
        prod = (prod + Half) >>> Point;
        acc  = (PW + 1)'(base) + (PW + 1)'(prod);
        if (acc > MaxV) begin
            lift = MaxV[DW-1:0];
        end else if (acc < MinV) begin
            lift = MinV[DW-1:0];
        end else begin
            lift = acc[DW-1:0];
        end
    endfunction

    state_e                   state_q;
    logic [Lanes-1:0][DW-1:0] he_q;
    logic [Lanes-1:0][DW-1:0] ho_q;
    logic [Lanes-1:0][DW-1:0] yp_q;
    logic                     hsof_q;
    logic                     first_q;

    logic [Lanes-1:0][DW-1:0] en_c;
    logic [Lanes-1:0][DW-1:0] ym_c;
    logic [Lanes-1:0][DW-1:0] yo_c;
    logic [Lanes-1:0][DW-1:0] ye_c;
    logic                     out_free;
    logic                     s_fire;
    logic                     out_ld;

    assign out_free  = !m_valid_o || m_ready_i;
    assign s_ready_o = (state_q != FLUSH) && out_free;
    assign s_fire    = s_valid_i && s_ready_o;
    assign out_ld    = (state_q == HELD && s_fire)
                    || (state_q == FLUSH && out_free);

    // FLUSH mirrors e[N-1]; the first pair of a row mirrors its own y_odd.
    always_comb begin
        en_c = '0;
        ym_c = '0;
        yo_c = '0;
        ye_c = '0;
        for (int k = 0; k < Lanes; k++) begin
            en_c[k] = (state_q == FLUSH) ? he_q[k] : s_data_i[k*LW +: DW];
            yo_c[k] = lift($signed(ho_q[k]),
                           SW'($signed(he_q[k])) + SW'($signed(en_c[k])),
                           PCoef);
            ym_c[k] = first_q ? yo_c[k] : yp_q[k];
            ye_c[k] = lift($signed(he_q[k]),
                           SW'($signed(ym_c[k])) + SW'($signed(yo_c[k])),
                           UCoef);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= EMPTY;
            he_q      <= '0;
            ho_q      <= '0;
            yp_q      <= '0;
            hsof_q    <= 1'b0;
            first_q   <= 1'b0;
            m_valid_o <= 1'b0;
            m_sof_o   <= 1'b0;
            m_eol_o   <= 1'b0;
            m_data_o  <= '0;
        end else begin
            if (out_ld) begin
                m_valid_o <= 1'b1;
                m_sof_o   <= hsof_q && first_q;
                m_eol_o   <= (state_q == FLUSH);
                for (int k = 0; k < Lanes; k++) begin
                    m_data_o[k*LW +: LW] <= {yo_c[k], ye_c[k]};
                end
            end else if (m_ready_i) begin
                m_valid_o <= 1'b0;
            end
            if (s_fire) begin
                for (int k = 0; k < Lanes; k++) begin
                    he_q[k] <= s_data_i[k*LW +: DW];
                    ho_q[k] <= s_data_i[k*LW+DW +: DW];
                end
                hsof_q  <= s_sof_i;
                first_q <= (state_q == EMPTY);
                if (state_q == HELD) begin
                    yp_q <= yo_c;
                end
                state_q <= s_eol_i ? FLUSH : HELD;
            end else if (state_q == FLUSH && out_ld) begin
                state_q <= EMPTY;
            end
        end
    end

endmodule
